// File: rtl/scan_decoder_pkg.sv
// Shared types and constants for the scan decoder: mode encoding, FSM states
// and the output-width derivation.
package scan_decoder_pkg;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIRECT = 2'd1,
        SCAN   = 2'd2
    } state_t;

    function automatic int out_width(input int sel_w);
        return 1 << sel_w;
    endfunction

endpackage

// File: rtl/scan_decoder_onehot_decoder.sv
// Combinational SEL_W -> 2**SEL_W one-hot decoder (active-high).
module onehot_decoder #(
    parameter int SEL_W = 2
) (
    input  logic [SEL_W-1:0]      sel,
    output logic [(2**SEL_W)-1:0] onehot
);

    for (genvar gi = 0; gi < 2**SEL_W; gi++) begin : g_line
        assign onehot[gi] = (sel == SEL_W'(gi));
    end

endmodule

// File: rtl/scan_decoder.sv
// Registered one-hot decoder with a direct-select mode and an auto-scan mode
// that walks indices 0..last, holding each for dwell+1 cycles.
module scan_decoder
    import scan_decoder_pkg::*;
#(
    parameter int SEL_W      = 2,
    parameter int DWELL_W    = 8,
    parameter int ACTIVE_LOW = 0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         en,
    input  logic                         mode,
    input  logic [SEL_W-1:0]             sel,
    input  logic [SEL_W-1:0]             last,
    input  logic [DWELL_W-1:0]           dwell,
    output logic [out_width(SEL_W)-1:0]  dec_out,
    output logic [SEL_W-1:0]             cur_idx,
    output logic                         valid,
    output logic                         wrap
);

    localparam int OUT_W = out_width(SEL_W);
    localparam logic [OUT_W-1:0] IDLE_PATTERN = (ACTIVE_LOW != 0) ? '1 : '0;

    state_t             state_reg, state_next;
    logic [SEL_W-1:0]   idx_reg, idx_next;
    logic [DWELL_W-1:0] cnt_reg, cnt_next;
    logic               valid_reg, valid_next;
    logic               wrap_reg, wrap_next;
    logic [OUT_W-1:0]   dec_reg, dec_next;
    logic [OUT_W-1:0]   onehot_next;

    // Decoding the next index keeps dec_out aligned with cur_idx in the same cycle.
    onehot_decoder #(
        .SEL_W (SEL_W)
    ) u_onehot (
        .sel    (idx_next),
        .onehot (onehot_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            idx_reg   <= '0;
            cnt_reg   <= '0;
            valid_reg <= 1'b0;
            wrap_reg  <= 1'b0;
            dec_reg   <= IDLE_PATTERN;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
            cnt_reg   <= cnt_next;
            valid_reg <= valid_next;
            wrap_reg  <= wrap_next;
            dec_reg   <= dec_next;
        end
    end

    always_comb begin
        state_next = IDLE;
        idx_next   = '0;
        cnt_next   = '0;
        valid_next = 1'b0;
        wrap_next  = 1'b0;
        if (en) begin
            valid_next = 1'b1;
            if (mode == MODE_DIRECT) begin
                state_next = DIRECT;
                idx_next   = sel;
            end else begin
                state_next = SCAN;
                // Entering SCAN keeps the index/counter defaults of 0.
                if (state_reg == SCAN) begin
                    if (cnt_reg == dwell) begin
                        if (idx_reg >= last) begin
                            wrap_next = 1'b1;
                        end else begin
                            idx_next = idx_reg + 1'b1;
                        end
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                        idx_next = idx_reg;
                    end
                end
            end
        end
        dec_next = valid_next ? (onehot_next ^ IDLE_PATTERN) : IDLE_PATTERN;
    end

    assign dec_out = dec_reg;
    assign cur_idx = idx_reg;
    assign valid   = valid_reg;
    assign wrap    = wrap_reg;

endmodule

// File: tb/tb_scan_decoder.sv
// Directed, table-driven bench for scan_decoder (SEL_W=2) plus an
// ACTIVE_LOW=1, SEL_W=3 instance for the inverted-polarity cases.
module tb_scan_decoder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       en = 1'b0, mode = 1'b0;
    logic [1:0] sel = '0, last = '0;
    logic [7:0] dwell = '0;
    logic [3:0] dec_out;
    logic [1:0] cur_idx;
    logic       valid, wrap;

    logic       en_al = 1'b0, mode_al = 1'b0;
    logic [2:0] sel_al = '0, last_al = '0;
    logic [7:0] dwell_al = '0;
    logic [7:0] dec_al;
    logic [2:0] idx_al;
    logic       valid_al, wrap_al;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    scan_decoder #(.SEL_W(2), .DWELL_W(8), .ACTIVE_LOW(0)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel(sel),
        .last(last), .dwell(dwell), .dec_out(dec_out), .cur_idx(cur_idx),
        .valid(valid), .wrap(wrap)
    );

    scan_decoder #(.SEL_W(3), .DWELL_W(8), .ACTIVE_LOW(1)) dut_al (
        .clk(clk), .rst_n(rst_n), .en(en_al), .mode(mode_al), .sel(sel_al),
        .last(last_al), .dwell(dwell_al), .dec_out(dec_al), .cur_idx(idx_al),
        .valid(valid_al), .wrap(wrap_al)
    );

    typedef struct {
        logic       en;
        logic       mode;
        logic [1:0] sel;
        logic [1:0] last;
        logic [7:0] dwell;
        logic [3:0] exp_dec;
        logic [1:0] exp_idx;
        logic       exp_valid;
        logic       exp_wrap;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input int idx, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s #%0d: got %0h expected %0h", name, idx, got, exp);
        end
    endtask

    function automatic void add(input logic e, input logic m, input logic [1:0] s,
                                input logic [1:0] l, input logic [7:0] d,
                                input logic [3:0] xd, input logic [1:0] xi,
                                input logic xv, input logic xw);
        vec_t v;
        v.en = e; v.mode = m; v.sel = s; v.last = l; v.dwell = d;
        v.exp_dec = xd; v.exp_idx = xi; v.exp_valid = xv; v.exp_wrap = xw;
        vecs.push_back(v);
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        // Idle and direct decode
        add(0, 0, 0, 0, 0, 4'b0000, 0, 0, 0);
        add(1, 0, 2, 0, 0, 4'b0100, 2, 1, 0);
        add(1, 0, 3, 0, 0, 4'b1000, 3, 1, 0);
        // Full scan, dwell=2 last=3: each index held 3 cycles, then wrap
        for (int i = 0; i < 12; i++) begin
            logic [1:0] ix;
            ix = 2'(i / 3);
            add(1, 1, 0, 3, 2, 4'b0001 << ix, ix, 1, 0);
        end
        add(1, 1, 0, 3, 2, 4'b0001, 0, 1, 1);
        add(1, 1, 0, 3, 2, 4'b0001, 0, 1, 0);
        add(1, 1, 0, 3, 2, 4'b0001, 0, 1, 0);
        add(1, 1, 0, 3, 2, 4'b0010, 1, 1, 0);
        add(1, 1, 0, 3, 2, 4'b0010, 1, 1, 0);
        add(1, 1, 0, 3, 2, 4'b0010, 1, 1, 0);
        add(1, 1, 0, 3, 2, 4'b0100, 2, 1, 0);
        // Mode switching at index 2, then scan restart, then disable
        add(1, 0, 1, 3, 2, 4'b0010, 1, 1, 0);
        add(1, 1, 1, 3, 2, 4'b0001, 0, 1, 0);
        add(0, 1, 1, 3, 2, 4'b0000, 0, 0, 0);
        // last=0, dwell=0: index 0 held, wrap every cycle after entry
        add(1, 1, 0, 0, 0, 4'b0001, 0, 1, 0);
        add(1, 1, 0, 0, 0, 4'b0001, 0, 1, 1);
        add(1, 1, 0, 0, 0, 4'b0001, 0, 1, 1);
        add(1, 1, 0, 0, 0, 4'b0001, 0, 1, 1);
        add(0, 1, 0, 0, 0, 4'b0000, 0, 0, 0);
        // last lowered below cur_idx mid-scan
        add(1, 1, 0, 3, 0, 4'b0001, 0, 1, 0);
        add(1, 1, 0, 3, 0, 4'b0010, 1, 1, 0);
        add(1, 1, 0, 3, 0, 4'b0100, 2, 1, 0);
        add(1, 1, 0, 3, 0, 4'b1000, 3, 1, 0);
        add(1, 1, 0, 1, 0, 4'b0001, 0, 1, 1);
        add(1, 1, 0, 1, 0, 4'b0010, 1, 1, 0);
        add(1, 1, 0, 1, 0, 4'b0001, 0, 1, 1);
        add(0, 1, 0, 1, 0, 4'b0000, 0, 0, 0);

        // Power-on reset, checked before any clock edge
        #2 rst_n = 1'b0;
        #1;
        check("por_dec", 0, 32'(dec_out), 32'h0);
        check("por_valid", 0, 32'(valid), 32'h0);
        check("por_al_dec", 0, 32'(dec_al), 32'hFF);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            en = vecs[i].en; mode = vecs[i].mode; sel = vecs[i].sel;
            last = vecs[i].last; dwell = vecs[i].dwell;
            @(posedge clk); #1;
            check("vec_dec", i, 32'(dec_out), 32'(vecs[i].exp_dec));
            check("vec_idx", i, 32'(cur_idx), 32'(vecs[i].exp_idx));
            check("vec_valid", i, 32'(valid), 32'(vecs[i].exp_valid));
            check("vec_wrap", i, 32'(wrap), 32'(vecs[i].exp_wrap));
            $display("vec %0d en=%0d mode=%0d sel=%0d last=%0d dwell=%0d -> dec=%b idx=%0d valid=%0d wrap=%0d",
                     i, en, mode, sel, last, dwell, dec_out, cur_idx, valid, wrap);
        end

        // Dwell lowered below the running count: counter wraps through 255 before matching
        en = 1'b1; mode = 1'b1; last = 2'd3; dwell = 8'd5;
        repeat (4) begin @(posedge clk); #1; end
        check("dwl_hold_idx", 0, 32'(cur_idx), 32'h0);
        dwell = 8'd1;
        n = 0;
        while (n < 400) begin
            @(posedge clk); #1;
            n++;
            if (cur_idx != 2'd0) break;
        end
        check("dwl_wrap_cycles", 0, 32'(n), 32'd255);
        check("dwl_wrap_idx", 0, 32'(cur_idx), 32'h1);
        $display("dwell wrap-around: index advanced after %0d cycles", n);

        // Asynchronous reset mid-scan, observed between clock edges
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        check("arst_dec", 0, 32'(dec_out), 32'h0);
        check("arst_idx", 0, 32'(cur_idx), 32'h0);
        check("arst_valid", 0, 32'(valid), 32'h0);
        check("arst_wrap", 0, 32'(wrap), 32'h0);
        check("arst_al_dec", 0, 32'(dec_al), 32'hFF);
        $display("async reset mid-scan: dec=%b idx=%0d valid=%0d wrap=%0d", dec_out, cur_idx, valid, wrap);
        en = 1'b0;
        #1 rst_n = 1'b1;

        // Active-low instance: direct sel=5, then idle
        en_al = 1'b1; mode_al = 1'b0; sel_al = 3'd5;
        @(posedge clk); #1;
        check("al_dec", 0, 32'(dec_al), 32'hDF);
        check("al_idx", 0, 32'(idx_al), 32'h5);
        check("al_valid", 0, 32'(valid_al), 32'h1);
        $display("active-low direct sel=5 -> dec=%b", dec_al);
        en_al = 1'b0;
        @(posedge clk); #1;
        check("al_idle_dec", 0, 32'(dec_al), 32'hFF);
        check("al_idle_valid", 0, 32'(valid_al), 32'h0);
        $display("active-low idle -> dec=%b", dec_al);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
